muldiv_unit: RTL
================

MULDIV_UNIT -- requirements
Module: muldiv_unit

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset; the ports SHALL be named clk and rst_n.
REQ-002 Parameter MULT_CYCLES, default 5: number of busy cycles for MULT/MULTU.
REQ-003 Parameter DIV_CYCLES, default 10: number of busy cycles for DIV/DIVU.
REQ-004 Port clk, input, 1: rising-edge clock.
REQ-005 Port rst_n, input, 1: asynchronous active-low reset.
REQ-006 Port start, input, 1: E-stage pulse that launches a MULT/MULTU/DIV/DIVU operation.
REQ-007 Port op, input, 3: 000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO, 11x no-op.
REQ-008 Port we, input, 1: E-stage write strobe for MTHI/MTLO.
REQ-009 Port a, input, 32: forwarded rs value from the E stage.
REQ-010 Port b, input, 32: forwarded rt value from the E stage.
REQ-011 Port busy, output, 1: an operation is in flight; consumed by the stall logic together with start.
REQ-012 Port hi, output, 32: architectural HI register, read by MFHI.
REQ-013 Port lo, output, 32: architectural LO register, read by MFLO.

Function
REQ-014 At a rising edge with start=1, busy=0 and op[2]=0, the block SHALL capture a, b and op, load its cycle counter with MULT_CYCLES or DIV_CYCLES, and set busy=1.
REQ-015 busy SHALL remain 1 for exactly N consecutive cycles after the launching edge (N = the loaded count).
REQ-016 At the edge that ends the Nth busy cycle, the block SHALL write hi and lo and clear busy in the same edge; the new values SHALL be visible in the first cycle with busy=0.
REQ-017 MULT SHALL write {hi,lo} = signed(a) x signed(b), a 64-bit product; MULTU SHALL produce the unsigned product.
REQ-018 DIV SHALL write lo = quotient truncated toward zero and hi = remainder with the sign of the dividend; DIVU SHALL use unsigned operands.
REQ-019 Signed DIV of 0x80000000 by 0xFFFFFFFF SHALL write lo=0x80000000 and hi=0x00000000.
REQ-020 DIV/DIVU with b=0 SHALL still assert busy for DIV_CYCLES cycles and SHALL leave hi and lo unchanged.
REQ-021 The block SHALL use operands captured at launch only; changes on a and b while busy SHALL have no effect.
REQ-022 At an edge with we=1, busy=0 and start=0, MTHI SHALL write hi<=a and MTLO SHALL write lo<=a; busy SHALL stay 0.
REQ-023 start and we while busy=1 SHALL be ignored, with no state change.
REQ-024 start and we asserted in the same cycle SHALL be resolved by start taking priority; the write SHALL be dropped.
REQ-025 start with op[2]=1, and we with op other than 100/101, SHALL be ignored.
REQ-026 State machine: IDLE -> RUN on a valid start; RUN decrements the counter each cycle; RUN -> IDLE when the counter reaches 1, committing the result. busy SHALL equal (state==RUN).
REQ-027 Any implementation (single-cycle compute plus delay, or iterative shift-subtract) is permitted provided the timing of REQ-015/REQ-016 is met exactly.

Reset
REQ-028 rst_n=0 SHALL immediately force busy=0, hi=0, lo=0, state=IDLE and counter=0, independent of clk.
REQ-029 A reset asserted mid-operation SHALL abort it; no result SHALL be committed after reset deasserts.
REQ-030 The first launch SHALL be accepted at the first rising edge after rst_n deasserts.

Verification
REQ-031 MULT, a=0xFFFFFFFE (-2), b=3 -> busy high for 5 cycles, then hi=0xFFFFFFFF and lo=0xFFFFFFFA.
REQ-032 DIV, a=-7, b=2 -> busy high for 10 cycles, then lo=0xFFFFFFFD (-3) and hi=0xFFFFFFFF (-1); DIVU on 7/2 -> lo=3, hi=1.
REQ-033 hi=0x11, lo=0x22, then DIVU with b=0 -> busy high for 10 cycles, then hi=0x11 and lo=0x22.
REQ-034 MTLO with a=0x1234 while busy -> ignored; MTLO after busy falls -> lo=0x1234 on the next cycle.
REQ-035 Start MULTU 0xFFFFFFFF x 0xFFFFFFFF, then pulse rst_n low in busy cycle 3 -> busy, hi and lo read 0 at once and remain 0 afterwards.
REQ-036 A second start in busy cycle 2 that also changes a and b -> ignored; the first result is committed exactly at cycle 5.

Source files
------------

// File: rtl/muldiv_unit.sv
`default_nettype none
// ============================================================================
//  Module      : muldiv_unit
//  Description : Multi-cycle MULT/MULTU/DIV/DIVU unit with HI/LO registers
//                and MTHI/MTLO write port. The result is computed from the
//                operands captured at launch and committed on the edge that
//                ends the last busy cycle.
//  Revision    : 1.0 - initial release
// ============================================================================
module muldiv_unit #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [2:0]  op,
    input  logic        we,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        busy,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    localparam int c_cnt_max = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int c_cnt_w   = (c_cnt_max < 2) ? 1 : $clog2(c_cnt_max + 1);

    localparam logic [c_cnt_w-1:0] c_mult_cnt = c_cnt_w'(MULT_CYCLES);
    localparam logic [c_cnt_w-1:0] c_div_cnt  = c_cnt_w'(DIV_CYCLES);
    localparam logic [c_cnt_w-1:0] c_cnt_one  = c_cnt_w'(1);
    localparam logic [c_cnt_w-1:0] c_cnt_zero = '0;

    localparam logic [2:0] c_op_mthi = 3'b100;
    localparam logic [2:0] c_op_mtlo = 3'b101;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t              state_q, state_d;
    logic [c_cnt_w-1:0]  cnt_q,   cnt_d;
    logic [1:0]          op_q,    op_d;     // op[1]: divide, op[0]: unsigned
    logic [31:0]         a_q,     a_d;
    logic [31:0]         b_q,     b_d;
    logic [31:0]         hi_q,    hi_d;
    logic [31:0]         lo_q,    lo_d;

    logic                w_is_signed;
    logic [63:0]         w_mul_a;
    logic [63:0]         w_mul_b;
    logic [63:0]         w_prod;
    logic                w_a_neg;
    logic                w_b_neg;
    logic [31:0]         w_a_mag;
    logic [31:0]         w_b_mag;
    logic [31:0]         w_b_safe;
    logic [31:0]         w_quo_mag;
    logic [31:0]         w_rem_mag;
    logic [31:0]         w_quo;
    logic [31:0]         w_rem;

    // Result datapath on the captured operands. Division works on magnitudes
    // so that quotient truncates toward zero and the remainder follows the
    // dividend; 0x80000000 / -1 falls out naturally as 0x80000000 rem 0.
    always_comb begin
        w_is_signed = ~op_q[0];
        w_mul_a     = w_is_signed ? {{32{a_q[31]}}, a_q} : {32'd0, a_q};
        w_mul_b     = w_is_signed ? {{32{b_q[31]}}, b_q} : {32'd0, b_q};
        w_prod      = w_mul_a * w_mul_b;

        w_a_neg     = w_is_signed & a_q[31];
        w_b_neg     = w_is_signed & b_q[31];
        w_a_mag     = w_a_neg ? (~a_q + 32'd1) : a_q;
        w_b_mag     = w_b_neg ? (~b_q + 32'd1) : b_q;
        // Divide-by-zero results are discarded; avoid an X-producing divisor.
        w_b_safe    = (w_b_mag == 32'd0) ? 32'd1 : w_b_mag;
        w_quo_mag   = w_a_mag / w_b_safe;
        w_rem_mag   = w_a_mag % w_b_safe;
        w_quo       = (w_a_neg ^ w_b_neg) ? (~w_quo_mag + 32'd1) : w_quo_mag;
        w_rem       = w_a_neg ? (~w_rem_mag + 32'd1) : w_rem_mag;
    end

    // Next-state logic: launch, countdown/commit, and MTHI/MTLO writes.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        op_d    = op_q;
        a_d     = a_q;
        b_d     = b_q;
        hi_d    = hi_q;
        lo_d    = lo_q;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    // start always wins over we; an invalid start is a no-op
                    if (!op[2]) begin
                        state_d = ST_RUN;
                        cnt_d   = op[1] ? c_div_cnt : c_mult_cnt;
                        op_d    = op[1:0];
                        a_d     = a;
                        b_d     = b;
                    end
                end else if (we) begin
                    if (op == c_op_mthi) begin
                        hi_d = a;
                    end else if (op == c_op_mtlo) begin
                        lo_d = a;
                    end
                end
            end
            ST_RUN: begin
                if (cnt_q == c_cnt_one) begin
                    state_d = ST_IDLE;
                    cnt_d   = c_cnt_zero;
                    if (!op_q[1]) begin
                        hi_d = w_prod[63:32];
                        lo_d = w_prod[31:0];
                    end else if (b_q != 32'd0) begin
                        hi_d = w_rem;
                        lo_d = w_quo;
                    end
                end else begin
                    cnt_d = cnt_q - c_cnt_one;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = c_cnt_zero;
            end
        endcase
    end

    // State and architectural registers; reset aborts any operation.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= c_cnt_zero;
            op_q    <= 2'b00;
            a_q     <= 32'd0;
            b_q     <= 32'd0;
            hi_q    <= 32'd0;
            lo_q    <= 32'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
            a_q     <= a_d;
            b_q     <= b_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
        end
    end

    assign busy = (state_q == ST_RUN);
    assign hi   = hi_q;
    assign lo   = lo_q;

endmodule
`default_nettype wire
